duration_entry_multi: RTL and testbench
=======================================

# duration_entry_multi

Multi-channel phase-duration entry block for the traffic-light controller. It holds one duration value per light phase (e.g. red/green/yellow) and edits them either by pushbutton stepping or by decoded IR remote codes. IR codes support multi-digit keypad entry with commit, cancel and timeout. It sits between the IR receiver (codes already decoded and synchronised into `clk`) and the countdown/display logic, which reads `value_out`.

## Interface
Parameters:
- `W`, 7: width of each stored duration.
- `CHANNELS`, 3: number of phase durations held.
- `DIGITS`, 2: maximum keypad digits per entry.
- `MIN`, 1: smallest legal value.
- `MAX`, 99: largest legal value. Must satisfy `MAX < 2^W`.
- `DEFAULT`, 30: reset value of every channel. Must satisfy `MIN <= DEFAULT <= MAX`.
- `TIMEOUT_CYC`, 150_000_000: idle cycles after which an entry is abandoned.
- `CODE_UP`, 8'h1B: IR code for step up.
- `CODE_DOWN`, 8'h1F: IR code for step down.
- `CODE_OK`, 8'h17: IR code that commits an entry.
- `CODE_CLR`, 8'h0C: IR code that cancels an entry.

Ports (`CW = max(1, $clog2(CHANNELS))`):
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  editing allowed; 0 ignores all inputs and aborts any entry.
- `mode`  in  1  0 = pushbutton editing, 1 = IR editing.
- `key_n`  in  1  active-low pushbutton, already debounced and synchronised.
- `up_down`  in  1  pushbutton direction: 1 = up, 0 = down.
- `sel`  in  CW  channel being edited.
- `ir_valid`  in  1  one-cycle pulse; `ir_code` is valid.
- `ir_code`  in  8  decoded IR command byte.
- `value_out`  out  CHANNELS*W  stored durations; channel i is at `[i*W +: W]`.
- `cur`  out  W  display value.
- `entering`  out  1  keypad entry in progress.
- `commit`  out  1  one-cycle pulse on any channel write.
- `err`  out  1  one-cycle pulse on a rejected or abandoned entry.

## Operation
- States: IDLE and ENTRY. Internal entry buffer is `4*DIGITS` bits wide. Range checks are done at that width before truncating to W.
- Inputs are ignored when `enable`=0. IR events are ignored when `mode`=0. `key_n` is ignored when `mode`=1.

Pushbutton (`mode`=0), IDLE only:
- Action occurs on a falling edge of `key_n` (registered previous sample), so one press gives exactly one step.
- Step up: value becomes value+1; MAX wraps to MIN.
- Step down: value becomes value−1; MIN wraps to MAX.
- The step applies to channel `sel` and pulses `commit`.

IR in IDLE:
- Digit d (0x00–0x09): go to ENTRY, buffer=d, digit count=1. The target channel is latched from `sel`.
- `CODE_UP`/`CODE_DOWN`: step channel `sel` as in pushbutton mode, with the same wrap rules; pulses `commit`.
- Any other code is ignored.

IR in ENTRY:
- Digit: buffer = buffer*10 + d, count+1.
- When count reaches DIGITS, auto-commit.
- `CODE_OK`: commit.
- `CODE_CLR`: return to IDLE with no write and no `err`.
- `CODE_UP`/`CODE_DOWN` and other codes: ignored; they do not reset the timeout.
- Commit with `MIN <= buffer <= MAX`: write the target channel, pulse `commit`, go to IDLE.
- Commit with buffer out of range: no write, pulse `err`, go to IDLE.

Other rules:
- Timeout counter clears on every accepted digit. On reaching TIMEOUT_CYC cycles: go to IDLE, pulse `err`, no write.
- `enable` falling during ENTRY: go to IDLE, no write, no `err`.
- A change of `sel` during ENTRY does not retarget the entry.
- `mode` toggling during ENTRY is treated like `enable`=0 (abort).
- `cur`: in IDLE, channel `sel`; in ENTRY, the buffer truncated to W.
- `entering` = (state==ENTRY).

## Timing
- Reset: every channel = DEFAULT, state IDLE, `commit`=`err`=`entering`=0, `cur`=DEFAULT, timeout counter 0, stored key sample = 1.
  - A key held low through reset does not count as a press.
- All outputs are registered.
- An event sampled at clock edge k (`ir_valid` high, or `key_n` falling edge detected) takes effect at edge k. At edge k, `value_out`, `cur`, `entering`, `commit` and `err` all update together.
- `commit` and `err` are high for exactly one cycle and are mutually exclusive.
- Back-to-back `ir_valid` pulses on consecutive cycles are each processed.
- `reset` has priority over everything and aborts ENTRY in the same cycle.

## Test plan
Bench parameters: W=7, CHANNELS=3, DIGITS=2, MIN=1, MAX=99, DEFAULT=30, TIMEOUT_CYC=100.

- Reset → `value_out` channels = {30,30,30}, `cur`=30, `entering`=0, `commit`=0.
- `mode`=1, `sel`=1, IR 0x04 then 0x05 → `cur` shows 4 then 45. Channel1=45 with one `commit` pulse on the second code. Channels 0 and 2 stay 30.
- IR 0x00, 0x00 → `err` pulse, channel unchanged. Then IR 0x07, `CODE_OK` → channel=7, `commit` pulse.
- Channel at 99 plus `CODE_UP` → 1. Channel at 1 plus `CODE_DOWN` → 99. Each gives one `commit`.
- `mode`=0, `up_down`=1, `key_n` held low 50 cycles from 30 → 31 only. Release and press again → 32. `ir_valid` pulses meanwhile cause no change.
- IR 0x03, then 100 idle cycles → `entering`=0, `err` pulse, value unchanged. IR 0x02, then `enable`=0 → abort, no `err`, no write.

Source files
------------

// File: rtl/duration_entry_multi.sv
// duration_entry_multi
// Holds one duration per traffic-light phase and edits them either by
// pushbutton stepping or by decoded IR remote codes (step keys, or
// multi-digit keypad entry with commit, cancel and idle timeout).
// The countdown/display logic reads value_out; cur is the value to display.

module duration_entry_multi #(
    parameter int          W           = 7,
    parameter int          CHANNELS    = 3,
    parameter int          DIGITS      = 2,
    parameter int          MIN         = 1,
    parameter int          MAX         = 99,
    parameter int          DEFAULT     = 30,
    parameter int          TIMEOUT_CYC = 150_000_000,
    parameter logic [7:0]  CODE_UP     = 8'h1B,
    parameter logic [7:0]  CODE_DOWN   = 8'h1F,
    parameter logic [7:0]  CODE_OK     = 8'h17,
    parameter logic [7:0]  CODE_CLR    = 8'h0C,
    localparam int         CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  key_n,
    input  logic                  up_down,
    input  logic [CW-1:0]         sel,
    input  logic                  ir_valid,
    input  logic [7:0]            ir_code,
    output logic [CHANNELS*W-1:0] value_out,
    output logic [W-1:0]          cur,
    output logic                  entering,
    output logic                  commit,
    output logic                  err
);

    // Entry buffer holds up to DIGITS decimal digits; 4 bits per digit always
    // leaves room for 10^DIGITS-1, so the buffer arithmetic never overflows.
    localparam int BW = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // One wrap-around step inside [MIN, MAX].
    function automatic logic [W-1:0] step_val(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        if (up) begin
            if (v == W'(MAX)) begin
                r = W'(MIN);
            end else begin
                r = v + W'(1);
            end
        end else begin
            if (v == W'(MIN)) begin
                r = W'(MAX);
            end else begin
                r = v - W'(1);
            end
        end
        return r;
    endfunction

    // Range check at full buffer width, before any truncation to W.
    function automatic logic in_range(input logic [BW-1:0] b);
        return (int'(b) >= MIN) && (int'(b) <= MAX);
    endfunction

    // Guards against select codes beyond the populated channels.
    function automatic logic chan_ok(input logic [CW-1:0] c);
        return int'(c) < CHANNELS;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_r;
    logic [W-1:0]    vals_r [CHANNELS];
    logic [BW-1:0]   buf_r;
    logic [NW-1:0]   cnt_r;
    logic [CW-1:0]   tgt_r;
    logic [TW-1:0]   tmo_r;
    logic            key_prev_r;
    logic            key_armed_r;
    logic [W-1:0]    cur_r;
    logic            entering_r;
    logic            commit_r;
    logic            err_r;

    state_t          nxt_state;
    logic [W-1:0]    nxt_vals [CHANNELS];
    logic [BW-1:0]   nxt_buf;
    logic [NW-1:0]   nxt_cnt;
    logic [CW-1:0]   nxt_tgt;
    logic [TW-1:0]   nxt_tmo;
    logic [W-1:0]    nxt_cur;
    logic            nxt_commit;
    logic            nxt_err;
    logic            do_finish_s;

    logic            key_fall_s;
    logic            sel_ok_s;
    logic            is_digit_s;
    logic [3:0]      dig_s;
    logic [BW-1:0]   acc_s;

    // A press counts only once the key has been seen released since reset,
    // so a key held through reset does not step anything.
    assign key_fall_s = key_armed_r & key_prev_r & ~key_n;
    assign sel_ok_s   = chan_ok(sel);
    assign is_digit_s = (ir_code <= 8'h09);
    assign dig_s      = ir_code[3:0];
    assign acc_s      = (buf_r * BW'(10)) + BW'(dig_s);

    // Next-state, next-value and pulse computation for the edit FSM.
    always_comb begin
        nxt_state   = state_r;
        nxt_vals    = vals_r;
        nxt_buf     = buf_r;
        nxt_cnt     = cnt_r;
        nxt_tgt     = tgt_r;
        nxt_tmo     = tmo_r;
        nxt_commit  = 1'b0;
        nxt_err     = 1'b0;
        do_finish_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!enable) begin
                    nxt_state = ST_IDLE;
                end else if (!mode) begin
                    if (key_fall_s && sel_ok_s) begin
                        nxt_vals[sel] = step_val(vals_r[sel], up_down);
                        nxt_commit    = 1'b1;
                    end else begin
                        nxt_commit    = 1'b0;
                    end
                end else if (ir_valid) begin
                    if (is_digit_s) begin
                        nxt_state   = ST_ENTRY;
                        nxt_buf     = BW'(dig_s);
                        nxt_cnt     = NW'(1);
                        nxt_tgt     = sel;
                        nxt_tmo     = {TW{1'b0}};
                        do_finish_s = (DIGITS == 1);
                    end else if ((ir_code == CODE_UP || ir_code == CODE_DOWN) && sel_ok_s) begin
                        nxt_vals[sel] = step_val(vals_r[sel], ir_code == CODE_UP);
                        nxt_commit    = 1'b1;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_state = ST_IDLE;
                end
            end

            ST_ENTRY: begin
                if (!enable || !mode) begin
                    // Silent abort: editing disabled or switched to pushbutton.
                    nxt_state = ST_IDLE;
                    nxt_cnt   = {NW{1'b0}};
                    nxt_tmo   = {TW{1'b0}};
                end else if (ir_valid && is_digit_s) begin
                    nxt_buf     = acc_s;
                    nxt_cnt     = cnt_r + NW'(1);
                    nxt_tmo     = {TW{1'b0}};
                    do_finish_s = ((cnt_r + NW'(1)) == NW'(DIGITS));
                end else if (ir_valid && ir_code == CODE_OK) begin
                    do_finish_s = 1'b1;
                end else if (ir_valid && ir_code == CODE_CLR) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = {NW{1'b0}};
                    nxt_tmo   = {TW{1'b0}};
                end else if (tmo_r == TW'(TIMEOUT_CYC - 1)) begin
                    // Step keys and unknown codes fall through here and do
                    // not refresh the idle timer.
                    nxt_state = ST_IDLE;
                    nxt_cnt   = {NW{1'b0}};
                    nxt_tmo   = {TW{1'b0}};
                    nxt_err   = 1'b1;
                end else begin
                    nxt_tmo   = tmo_r + TW'(1);
                end
            end

            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = {NW{1'b0}};
                nxt_tmo   = {TW{1'b0}};
            end
        endcase

        if (do_finish_s) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = {NW{1'b0}};
            nxt_tmo   = {TW{1'b0}};
            if (in_range(nxt_buf) && chan_ok(nxt_tgt)) begin
                nxt_vals[nxt_tgt] = W'(nxt_buf);
                nxt_commit        = 1'b1;
            end else begin
                nxt_err           = 1'b1;
            end
        end else begin
            nxt_commit = nxt_commit;
        end

        if (nxt_state == ST_ENTRY) begin
            nxt_cur = W'(nxt_buf);
        end else if (sel_ok_s) begin
            nxt_cur = nxt_vals[sel];
        end else begin
            nxt_cur = {W{1'b0}};
        end
    end

    // FSM state, stored durations and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < CHANNELS; i++) begin
                vals_r[i] <= W'(DEFAULT);
            end
            buf_r       <= {BW{1'b0}};
            cnt_r       <= {NW{1'b0}};
            tgt_r       <= {CW{1'b0}};
            tmo_r       <= {TW{1'b0}};
            key_prev_r  <= 1'b1;
            key_armed_r <= key_n;
            cur_r       <= W'(DEFAULT);
            entering_r  <= 1'b0;
            commit_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= nxt_state;
            vals_r      <= nxt_vals;
            buf_r       <= nxt_buf;
            cnt_r       <= nxt_cnt;
            tgt_r       <= nxt_tgt;
            tmo_r       <= nxt_tmo;
            key_prev_r  <= key_n;
            key_armed_r <= key_armed_r | key_n;
            cur_r       <= nxt_cur;
            entering_r  <= (nxt_state == ST_ENTRY);
            commit_r    <= nxt_commit;
            err_r       <= nxt_err;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign value_out[g*W +: W] = vals_r[g];
    end

    assign cur      = cur_r;
    assign entering = entering_r;
    assign commit   = commit_r;
    assign err      = err_r;

endmodule

// File: tb/tb_duration_entry_multi.sv
// Self-checking bench for duration_entry_multi: directed table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.

module tb_duration_entry_multi;

    localparam int W  = 7;
    localparam int CH = 3;
    localparam int TO = 100;
    localparam logic [7:0] C_UP   = 8'h1B;
    localparam logic [7:0] C_DOWN = 8'h1F;
    localparam logic [7:0] C_OK   = 8'h17;
    localparam logic [7:0] C_CLR  = 8'h0C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, mode, key_n, up_down, ir_valid;
    logic [1:0]    sel;
    logic [7:0]    ir_code;
    logic [CH*W-1:0] value_out;
    logic [W-1:0]  cur;
    logic          entering, commit, err;

    int checks = 0;
    int errors = 0;

    duration_entry_multi #(
        .W(W), .CHANNELS(CH), .DIGITS(2), .MIN(1), .MAX(99), .DEFAULT(30),
        .TIMEOUT_CYC(TO), .CODE_UP(C_UP), .CODE_DOWN(C_DOWN),
        .CODE_OK(C_OK), .CODE_CLR(C_CLR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .key_n(key_n),
        .up_down(up_down), .sel(sel), .ir_valid(ir_valid), .ir_code(ir_code),
        .value_out(value_out), .cur(cur), .entering(entering),
        .commit(commit), .err(err)
    );

    // ---------------- behavioural reference model ----------------
    int m_ch[CH];
    bit m_entry;
    int m_buf, m_digits, m_tgt, m_idle;
    bit m_prev, m_seen_high;
    int m_cur;
    bit m_commit, m_err;

    function automatic int stepf(input int v, input bit up);
        if (up) return (v == 99) ? 1 : v + 1;
        else    return (v == 1) ? 99 : v - 1;
    endfunction

    task automatic m_finish();
        m_entry = 0;
        if (m_buf >= 1 && m_buf <= 99) begin
            m_ch[m_tgt] = m_buf;
            m_commit = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic model_step();
        bit press;
        m_commit = 0;
        m_err = 0;
        if (reset) begin
            for (int i = 0; i < CH; i++) m_ch[i] = 30;
            m_entry = 0; m_buf = 0; m_digits = 0; m_idle = 0;
            m_prev = 1; m_seen_high = key_n; m_cur = 30;
            return;
        end
        press = m_seen_high && m_prev && !key_n;
        if (!enable) begin
            m_entry = 0;
        end else if (!m_entry) begin
            if (!mode) begin
                if (press) begin m_ch[sel] = stepf(m_ch[sel], up_down); m_commit = 1; end
            end else if (ir_valid) begin
                if (ir_code <= 8'd9) begin
                    m_entry = 1; m_buf = int'(ir_code); m_digits = 1; m_tgt = int'(sel); m_idle = 0;
                end else if (ir_code == C_UP || ir_code == C_DOWN) begin
                    m_ch[sel] = stepf(m_ch[sel], ir_code == C_UP); m_commit = 1;
                end
            end
        end else begin
            if (!mode) begin
                m_entry = 0;
            end else if (ir_valid && ir_code <= 8'd9) begin
                m_buf = m_buf * 10 + int'(ir_code); m_digits++; m_idle = 0;
                if (m_digits == 2) m_finish();
            end else if (ir_valid && ir_code == C_OK) begin
                m_finish();
            end else if (ir_valid && ir_code == C_CLR) begin
                m_entry = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_entry = 0; m_err = 1; end
            end
        end
        m_seen_high = m_seen_high | key_n;
        m_prev = key_n;
        m_cur = m_entry ? (m_buf % 128) : m_ch[sel];
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int chv(input int i);
        return int'(value_out[i*W +: W]);
    endfunction

    // One clock: model consumes the current inputs, DUT samples them at the
    // edge, outputs are compared 1 time unit later.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) chk($sformatf("model_ch%0d", i), chv(i), m_ch[i]);
        chk("model_cur", int'(cur), m_cur);
        chk("model_entering", int'(entering), int'(m_entry));
        chk("model_commit", int'(commit), int'(m_commit));
        chk("model_err", int'(err), int'(m_err));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic rst, en, md;
        logic [1:0] sl;
        logic iv;
        logic [7:0] code;
        int e0, e1, e2, ecur;
        logic eent, ecom, eerr;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic rst, en, md, input logic [1:0] sl,
                                input logic iv, input logic [7:0] code,
                                input int e0, e1, e2, ecur,
                                input logic eent, ecom, eerr);
        vec_t v;
        v.rst = rst; v.en = en; v.md = md; v.sl = sl; v.iv = iv; v.code = code;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.ecur = ecur;
        v.eent = eent; v.ecom = ecom; v.eerr = eerr;
        return v;
    endfunction

    int ncom, nerr;

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 1'b0; key_n = 1'b1; up_down = 1'b1;
        sel = 2'd0; ir_valid = 1'b0; ir_code = 8'h00;

        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 30, 30, 30, 30, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h04, 30, 30, 30,  4, 1'b1, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h05, 30, 45, 30, 45, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h00, 30, 45, 30,  0, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h00, 30, 45, 30, 45, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h07, 30, 45, 30,  7, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, C_OK,  30,  7, 30,  7, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 30,  7, 30, 30, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h09, 30,  7, 30,  9, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h09, 30, 99, 30, 99, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, C_UP,  30,  1, 30,  1, 1'b0, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, C_DOWN,30, 99, 30, 99, 1'b0, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 2'd1, 1'b1, C_DOWN,30, 98, 30, 98, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, C_UP,  30, 98, 31, 31, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; mode = tbl[i].md; sel = tbl[i].sl;
            ir_valid = tbl[i].iv; ir_code = tbl[i].code;
            cyc();
            chk($sformatf("tbl%0d_ch0", i), chv(0), tbl[i].e0);
            chk($sformatf("tbl%0d_ch1", i), chv(1), tbl[i].e1);
            chk($sformatf("tbl%0d_ch2", i), chv(2), tbl[i].e2);
            chk($sformatf("tbl%0d_cur", i), int'(cur), tbl[i].ecur);
            chk($sformatf("tbl%0d_entering", i), int'(entering), int'(tbl[i].eent));
            chk($sformatf("tbl%0d_commit", i), int'(commit), int'(tbl[i].ecom));
            chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].eerr));
        end
        ir_valid = 1'b0;

        // Held key steps once; IR pulses in pushbutton mode are ignored.
        mode = 1'b0; sel = 2'd0; up_down = 1'b1; key_n = 1'b1;
        cyc();
        ncom = 0;
        key_n = 1'b0;
        for (int i = 0; i < 50; i++) begin
            ir_valid = i[0]; ir_code = C_UP;
            cyc();
            if (commit) ncom++;
        end
        ir_valid = 1'b0;
        chk("hold_ch0", chv(0), 31);
        chk("hold_commits", ncom, 1);
        key_n = 1'b1;
        repeat (3) cyc();
        key_n = 1'b0;
        cyc();
        chk("press2_commit", int'(commit), 1);
        chk("press2_ch0", chv(0), 32);
        key_n = 1'b1;
        cyc();

        // Entry abandoned after exactly TO idle cycles.
        mode = 1'b1; ir_valid = 1'b1; ir_code = 8'h03;
        cyc();
        chk("to_start_entering", int'(entering), 1);
        chk("to_start_cur", int'(cur), 3);
        ir_valid = 1'b0;
        nerr = 0;
        for (int i = 0; i < TO - 1; i++) begin
            cyc();
            if (err) nerr++;
        end
        chk("to_still_entering", int'(entering), 1);
        chk("to_no_early_err", nerr, 0);
        cyc();
        chk("to_entering", int'(entering), 0);
        chk("to_err", int'(err), 1);
        chk("to_ch0", chv(0), 32);

        // enable dropping aborts silently.
        ir_valid = 1'b1; ir_code = 8'h02;
        cyc();
        chk("en_start_entering", int'(entering), 1);
        ir_valid = 1'b0; enable = 1'b0;
        cyc();
        chk("en_abort_entering", int'(entering), 0);
        chk("en_abort_err", int'(err), 0);
        chk("en_abort_commit", int'(commit), 0);
        chk("en_abort_ch0", chv(0), 32);
        chk("en_abort_cur", int'(cur), 32);
        enable = 1'b1;
        cyc();

        // Key held low through reset is not a press.
        mode = 1'b0; key_n = 1'b0; reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        ncom = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (commit) ncom++;
        end
        chk("rsthold_commits", ncom, 0);
        chk("rsthold_ch0", chv(0), 30);
        key_n = 1'b1;
        cyc();
        key_n = 1'b0;
        cyc();
        chk("rsthold_press_ch0", chv(0), 31);

        // Randomized stimulus against the model.
        mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset   = ($urandom_range(0, 399) == 0);
            enable  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 79) == 0) mode = ~mode;
            if ($urandom_range(0, 3) == 0) key_n = ~key_n;
            up_down = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 2));
            ir_valid = ((n % 600) < 450) && ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r <= 5)      ir_code = 8'($urandom_range(0, 9));
            else if (r == 6) ir_code = C_UP;
            else if (r == 7) ir_code = C_DOWN;
            else if (r == 8) ir_code = C_OK;
            else if ($urandom_range(0, 1) == 0) ir_code = C_CLR;
            else             ir_code = 8'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
